// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential restoring divider.
//   DIV_SIZE_DEF : default operand width (dividend/quotient are twice this)
//   div_state_e  : controller states IDLE -> RUN -> DONE -> IDLE
// -----------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_SIZE_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage : div_pkg

// File: rtl/div_if.sv
// -----------------------------------------------------------------------------
// div_if
// Start/done handshake and operand/result bus of the divider.
//   start, dividend[2*SIZE], divisor[SIZE]         : requester -> divider
//   busy, done, quotient[2*SIZE], remainder[SIZE],
//   div_zero, ovf (only with DIV_OVF_FLAG_EN)       : divider -> requester
// Modports: master (requester side), slave (divider side).
// Optional feature macro: DIV_OVF_FLAG_EN adds the ovf signal.
// -----------------------------------------------------------------------------
interface div_if
    import div_pkg::*;
#(
    parameter int SIZE = DIV_SIZE_DEF
) ();

    logic                start;
    logic [2*SIZE-1:0]   dividend;
    logic [SIZE-1:0]     divisor;
    logic                busy;
    logic                done;
    logic [2*SIZE-1:0]   quotient;
    logic [SIZE-1:0]     remainder;
    logic                div_zero;
`ifdef DIV_OVF_FLAG_EN
    logic                ovf;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_zero, ovf
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_zero, ovf
    );
`else
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_zero
    );
`endif

endinterface : div_if

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division iteration.
//   rem      in  SIZE+1  current partial remainder
//   din      in  1       next dividend bit (MSB first)
//   divisor  in  SIZE    divisor
//   rem_next out SIZE+1  partial remainder after this iteration
//   qbit     out 1       quotient bit produced by this iteration
// -----------------------------------------------------------------------------
module div_step
    import div_pkg::*;
#(
    parameter int SIZE = DIV_SIZE_DEF
) (
    input  logic [SIZE:0]   rem,
    input  logic            din,
    input  logic [SIZE-1:0] divisor,
    output logic [SIZE:0]   rem_next,
    output logic            qbit
);

    logic [SIZE:0] shifted_s;
    logic [SIZE:0] diff_s;

    // Shift in the next dividend bit and subtract when the divisor fits.
    // The partial remainder stays below the divisor, so its top bit is
    // normally clear; if it were set, the shifted value would certainly
    // exceed the divisor, hence the OR into the compare.
    always_comb begin
        shifted_s = {rem[SIZE-1:0], din};
        diff_s    = shifted_s - {1'b0, divisor};
        if (rem[SIZE] || (shifted_s >= {1'b0, divisor})) begin
            qbit     = 1'b1;
            rem_next = diff_s;
        end else begin
            qbit     = 1'b0;
            rem_next = shifted_s;
        end
    end

endmodule : div_step

// File: rtl/div_seq.sv
// -----------------------------------------------------------------------------
// div_seq
// Sequential unsigned restoring divider, one quotient bit per clock.
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    div_if.slave: start/dividend/divisor in; busy/done/quotient/
//          remainder/div_zero (and ovf) out, all registered.
// A start seen in IDLE is accepted; divide-by-zero finishes in one cycle,
// otherwise done pulses 2*SIZE cycles after accept.
// Optional feature macro: DIV_OVF_FLAG_EN (quotient-wider-than-SIZE flag).
// -----------------------------------------------------------------------------
module div_seq
    import div_pkg::*;
#(
    parameter int SIZE = DIV_SIZE_DEF
) (
    input  logic  clk,
    input  logic  rst_n,
    div_if.slave  bus
);

    localparam int               CNT_W    = $clog2(2*SIZE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2*SIZE-1);

    div_state_e          state_r;
    div_state_e          state_next_s;

    logic                accept_s;
    logic                run_s;
    logic                last_s;
    logic                zero_s;
    logic                busy_next_s;
    logic                done_next_s;

    logic [CNT_W-1:0]    cnt_r;
    logic [2*SIZE-1:0]   dvd_r;
    logic [SIZE-1:0]     dvs_r;
    logic [SIZE:0]       rem_r;
    logic [2*SIZE-2:0]   quo_r;

    logic [SIZE:0]       rem_next_s;
    logic                qbit_s;
    logic [2*SIZE-1:0]   quo_shift_s;

    logic                busy_r;
    logic                done_r;
    logic [2*SIZE-1:0]   quotient_r;
    logic [SIZE-1:0]     remainder_r;
    logic                div_zero_r;

    assign zero_s      = (bus.divisor == {SIZE{1'b0}});
    assign quo_shift_s = {quo_r, qbit_s};

    div_step #(.SIZE(SIZE)) u_step (
        .rem      (rem_r),
        .din      (dvd_r[2*SIZE-1]),
        .divisor  (dvs_r),
        .rem_next (rem_next_s),
        .qbit     (qbit_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: zero divisor skips the iteration phase.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    if (zero_s) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = RUN;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == CNT_LAST) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Control decode; busy/done are registered copies of the next state.
    always_comb begin
        accept_s = 1'b0;
        run_s    = 1'b0;
        last_s   = 1'b0;
        case (state_r)
            IDLE:    accept_s = bus.start;
            RUN: begin
                run_s  = 1'b1;
                last_s = (cnt_r == CNT_LAST);
            end
            DONE:    accept_s = 1'b0;
            default: accept_s = 1'b0;
        endcase
        busy_next_s = (state_next_s != IDLE);
        done_next_s = (state_next_s == DONE);
    end

    // Handshake output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= busy_next_s;
            done_r <= done_next_s;
        end
    end

    // Datapath: operand capture, MSB-first iteration, result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r       <= {CNT_W{1'b0}};
            dvd_r       <= {(2*SIZE){1'b0}};
            dvs_r       <= {SIZE{1'b0}};
            rem_r       <= {(SIZE+1){1'b0}};
            quo_r       <= {(2*SIZE-1){1'b0}};
            quotient_r  <= {(2*SIZE){1'b0}};
            remainder_r <= {SIZE{1'b0}};
            div_zero_r  <= 1'b0;
        end else if (accept_s) begin
            cnt_r      <= {CNT_W{1'b0}};
            dvd_r      <= bus.dividend;
            dvs_r      <= bus.divisor;
            rem_r      <= {(SIZE+1){1'b0}};
            quo_r      <= {(2*SIZE-1){1'b0}};
            div_zero_r <= zero_s;
            // Divide-by-zero results are known at accept and published
            // alongside the done pulse that follows.
            if (zero_s) begin
                quotient_r  <= {(2*SIZE){1'b1}};
                remainder_r <= bus.dividend[SIZE-1:0];
            end else begin
                quotient_r  <= quotient_r;
                remainder_r <= remainder_r;
            end
        end else if (run_s) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            dvd_r <= {dvd_r[2*SIZE-2:0], 1'b0};
            rem_r <= rem_next_s;
            quo_r <= quo_shift_s[2*SIZE-2:0];
            if (last_s) begin
                quotient_r  <= quo_shift_s;
                remainder_r <= rem_next_s[SIZE-1:0];
            end else begin
                quotient_r  <= quotient_r;
                remainder_r <= remainder_r;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

`ifdef DIV_OVF_FLAG_EN
    logic ovf_acc_s;
    logic ovf_pend_r;
    logic ovf_r;

    // Quotient exceeds SIZE bits exactly when the upper dividend half
    // is not smaller than the divisor.
    assign ovf_acc_s = !zero_s && (bus.dividend[2*SIZE-1:SIZE] >= bus.divisor);

    // Overflow flag: evaluated at accept, published with the quotient.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_pend_r <= 1'b0;
            ovf_r      <= 1'b0;
        end else if (accept_s) begin
            ovf_pend_r <= ovf_acc_s;
            if (zero_s) begin
                ovf_r <= 1'b0;
            end else begin
                ovf_r <= ovf_r;
            end
        end else if (last_s) begin
            ovf_r <= ovf_pend_r;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign bus.ovf = ovf_r;
`endif

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.quotient  = quotient_r;
    assign bus.remainder = remainder_r;
    assign bus.div_zero  = div_zero_r;

endmodule : div_seq
